// File: rtl/taxi_qsfp_port_ctrl.sv
// taxi_qsfp_port_ctrl
// -------------------
// Per-port QSFP28 module management sequencer sitting between the cage pins
// and the Ethernet core. Each port synchronises and debounces modprsl, then
// runs a reset/init sequence (resetl low, then t_init wait) before
// reporting ready. Module interrupts are latched into a sticky flag while the
// port is ready.
//
// Optional build feature:
//   TAXI_QSFP_LPMODE_EN  when defined, lpmode is held high until the port
//                        reaches READY; when undefined, lpmode is tied low.
//
// Ports (bit i of every vector belongs to port i):
//   clk             module clock
//   rst             asynchronous active-high reset
//   pll_locked      Ethernet reference PLL lock (asynchronous)
//   port_modprsl    module present, active-low (asynchronous)
//   port_intl       module interrupt, active-low (asynchronous)
//   port_reset_req  one-cycle software reset request
//   int_clear       one-cycle clear of the sticky interrupt flag
//   port_resetl     module reset, active-low
//   port_lpmode     module low-power mode
//   port_present    debounced presence
//   port_ready      module initialised, MAC may enable
//   port_int        sticky interrupt flag
module taxi_qsfp_port_ctrl #(
  parameter int PORT_CNT        = 15,
  parameter int DEBOUNCE_CYCLES = 125000,
  parameter int RESET_CYCLES    = 1250,
  parameter int INIT_CYCLES     = 250000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pll_locked,
  input  logic [PORT_CNT-1:0] port_modprsl,
  input  logic [PORT_CNT-1:0] port_intl,
  input  logic [PORT_CNT-1:0] port_reset_req,
  input  logic [PORT_CNT-1:0] int_clear,
  output logic [PORT_CNT-1:0] port_resetl,
  output logic [PORT_CNT-1:0] port_lpmode,
  output logic [PORT_CNT-1:0] port_present,
  output logic [PORT_CNT-1:0] port_ready,
  output logic [PORT_CNT-1:0] port_int
);

  // Counter width is derived from the longest interval; not a parameter.
  localparam int MAX_RD  = (RESET_CYCLES > DEBOUNCE_CYCLES) ? RESET_CYCLES : DEBOUNCE_CYCLES;
  localparam int MAX_CYC = (INIT_CYCLES > MAX_RD) ? INIT_CYCLES : MAX_RD;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_ABSENT,
    ST_RESET,
    ST_INIT,
    ST_READY
  } state_t;

  // Two-flop synchronisers, reset to the inactive pin levels.
  logic                lock_s1, lock_s2;
  logic [PORT_CNT-1:0] modprsl_s1, modprsl_s2;
  logic [PORT_CNT-1:0] intl_s1, intl_s2;

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_s1    <= 1'b0;
      lock_s2    <= 1'b0;
      modprsl_s1 <= '1;
      modprsl_s2 <= '1;
      intl_s1    <= '1;
      intl_s2    <= '1;
    end else begin
      lock_s1    <= pll_locked;
      lock_s2    <= lock_s1;
      modprsl_s1 <= port_modprsl;
      modprsl_s2 <= modprsl_s1;
      intl_s1    <= port_intl;
      intl_s2    <= intl_s1;
    end
  end

  for (genvar g = 0; g < PORT_CNT; g++) begin : g_port
    // ---------------- presence debounce ----------------
    logic             accepted;   // accepted modprsl level (active-low)
    logic [CNT_W-1:0] deb_cnt;
    logic             present;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        accepted <= 1'b1;
        deb_cnt  <= '0;
      end else if (modprsl_s2[g] != accepted) begin
        // Any sample equal to the accepted level restarts the run below.
        if (deb_cnt == DEB_LAST) begin
          accepted <= modprsl_s2[g];
          deb_cnt  <= '0;
        end else if (deb_cnt != CNT_MAX) begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end

    assign present = ~accepted;

    // ---------------- sequencer FSM ----------------
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic             resetl_q, ready_q, int_q;

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    // NOTE: every signal written here gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt_inc;
      if (state != ST_ABSENT && (!present || !lock_s2)) begin
        // Removal outranks PLL loss, which outranks a software request.
        state_nxt = ST_ABSENT;
        cnt_nxt   = '0;
      end else if (state != ST_ABSENT && port_reset_req[g]) begin
        state_nxt = ST_RESET;
        cnt_nxt   = '0;
      end else begin
        case (state)
          ST_ABSENT: begin
            cnt_nxt = '0;
            if (present && lock_s2) state_nxt = ST_RESET;
          end
          ST_RESET: begin
            if (cnt == RST_LAST) begin
              state_nxt = ST_INIT;
              cnt_nxt   = '0;
            end
          end
          ST_INIT: begin
            if (cnt == INIT_LAST) begin
              state_nxt = ST_READY;
              cnt_nxt   = '0;
            end
          end
          ST_READY: cnt_nxt = '0;
          default: begin
            state_nxt = ST_ABSENT;
            cnt_nxt   = '0;
          end
        endcase
      end
    end

    // Outputs are registered from the next state so they change on the
    // same edge as the state itself.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state    <= ST_ABSENT;
        cnt      <= '0;
        resetl_q <= 1'b0;
        ready_q  <= 1'b0;
        int_q    <= 1'b0;
      end else begin
        state    <= state_nxt;
        cnt      <= cnt_nxt;
        resetl_q <= (state_nxt == ST_INIT) || (state_nxt == ST_READY);
        ready_q  <= (state_nxt == ST_READY);
        if (state == ST_READY && state_nxt == ST_READY) begin
          // A new interrupt wins over a coincident clear.
          if (!intl_s2[g])        int_q <= 1'b1;
          else if (int_clear[g])  int_q <= 1'b0;
        end else begin
          int_q <= 1'b0;
        end
      end
    end

    assign port_present[g] = present;
    assign port_resetl[g]  = resetl_q;
    assign port_ready[g]   = ready_q;
    assign port_int[g]     = int_q;

`ifdef TAXI_QSFP_LPMODE_EN
    // Module stays in low-power mode until its init wait has completed.
    logic lpmode_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) lpmode_q <= 1'b0;
      else     lpmode_q <= (state_nxt != ST_READY);
    end

    assign port_lpmode[g] = lpmode_q;
`else
    assign port_lpmode[g] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_taxi_qsfp_port_ctrl.sv
// Self-checking bench for taxi_qsfp_port_ctrl with short timing parameters.
// A time-based reference model runs alongside every directed and random
// cycle; directed sequences add explicit checks for the key corner cases.
module tb_taxi_qsfp_port_ctrl;

  localparam int P      = 15;
  localparam int DEB    = 4;
  localparam int RST_C  = 8;
  localparam int INIT_C = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         pll_locked;
  logic [P-1:0] port_modprsl, port_intl, port_reset_req, int_clear;
  logic [P-1:0] port_resetl, port_lpmode, port_present, port_ready, port_int;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  taxi_qsfp_port_ctrl #(
    .PORT_CNT        (P),
    .DEBOUNCE_CYCLES (DEB),
    .RESET_CYCLES    (RST_C),
    .INIT_CYCLES     (INIT_C)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pll_locked     (pll_locked),
    .port_modprsl   (port_modprsl),
    .port_intl      (port_intl),
    .port_reset_req (port_reset_req),
    .int_clear      (int_clear),
    .port_resetl    (port_resetl),
    .port_lpmode    (port_lpmode),
    .port_present   (port_present),
    .port_ready     (port_ready),
    .port_int       (port_int)
  );

  task automatic check(input string name, input logic [P-1:0] act, input logic [P-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Presence is a run-length of disagreeing samples; the sequence is an
  // elapsed-time counter since the last (re)start: resetl rises at RST_C,
  // ready at RST_C+INIT_C.
  logic [P-1:0] m_mp_s1, m_mp_s2, m_il_s1, m_il_s2, m_acc, m_int;
  logic         m_lk_s1, m_lk_s2;
  int           m_run    [P];
  bit           m_active [P];
  int           m_t      [P];
  bit           m_edged;

  task automatic model_reset();
    m_mp_s1 = '1; m_mp_s2 = '1; m_il_s1 = '1; m_il_s2 = '1;
    m_acc = '1; m_int = '0; m_lk_s1 = 1'b0; m_lk_s2 = 1'b0; m_edged = 1'b0;
    for (int i = 0; i < P; i++) begin
      m_run[i] = 0; m_active[i] = 1'b0; m_t[i] = 0;
    end
  endtask

  function automatic logic [P-1:0] exp_ready();
    logic [P-1:0] r;
    for (int i = 0; i < P; i++) r[i] = m_active[i] && (m_t[i] >= RST_C + INIT_C);
    return r;
  endfunction

  function automatic logic [P-1:0] exp_resetl();
    logic [P-1:0] r;
    for (int i = 0; i < P; i++) r[i] = m_active[i] && (m_t[i] >= RST_C);
    return r;
  endfunction

  function automatic logic [P-1:0] exp_lpmode();
`ifdef TAXI_QSFP_LPMODE_EN
    return m_edged ? ~exp_ready() : '0;
`else
    return '0;
`endif
  endfunction

  task automatic model_edge();
    logic [P-1:0] pres_old, il_old, mp_old, rdy_old, rdy_new;
    logic         lk_old;
    pres_old = ~m_acc;
    il_old   = m_il_s2;
    mp_old   = m_mp_s2;
    lk_old   = m_lk_s2;
    rdy_old  = exp_ready();
    m_lk_s2 = m_lk_s1; m_lk_s1 = pll_locked;
    m_mp_s2 = m_mp_s1; m_mp_s1 = port_modprsl;
    m_il_s2 = m_il_s1; m_il_s1 = port_intl;
    for (int i = 0; i < P; i++) begin
      if (mp_old[i] != m_acc[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_acc[i] = mp_old[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      if (m_active[i]) begin
        if (!pres_old[i] || !lk_old) m_active[i] = 1'b0;
        else if (port_reset_req[i])  m_t[i] = 0;
        else if (m_t[i] < RST_C + INIT_C) m_t[i]++;
      end else if (pres_old[i] && lk_old) begin
        m_active[i] = 1'b1;
        m_t[i] = 0;
      end
    end
    rdy_new = exp_ready();
    for (int i = 0; i < P; i++) begin
      if (rdy_old[i] && rdy_new[i]) begin
        if (!il_old[i])        m_int[i] = 1'b1;
        else if (int_clear[i]) m_int[i] = 1'b0;
      end else begin
        m_int[i] = 1'b0;
      end
    end
    m_edged = 1'b1;
  endtask

  // One clock: advance the model with the inputs seen at the edge, then
  // compare every output just after the edge.
  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    check("model_present", port_present, ~m_acc);
    check("model_resetl",  port_resetl,  exp_resetl());
    check("model_ready",   port_ready,   exp_ready());
    check("model_int",     port_int,     m_int);
    check("model_lpmode",  port_lpmode,  exp_lpmode());
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_present"}, port_present, '0);
    check({tag, "_resetl"},  port_resetl,  '0);
    check({tag, "_ready"},   port_ready,   '0);
    check({tag, "_int"},     port_int,     '0);
    check({tag, "_lpmode"},  port_lpmode,  '0);
  endtask

  // Insertion of port 3: edges after modprsl falls vs expected port-3 outputs.
  typedef struct {
    int   edges;
    logic present;
    logic resetl;
    logic ready;
  } ins_vec_t;

  localparam logic [P-1:0] M3 = P'(1) << 3;
  localparam logic [P-1:0] M5 = P'(1) << 5;
  localparam logic [P-1:0] M2 = P'(1) << 2;

  initial begin
    ins_vec_t ins_tbl [6];
    int       n;
    ins_tbl = '{
      '{5,  1'b0, 1'b0, 1'b0},
      '{6,  1'b1, 1'b0, 1'b0},
      '{14, 1'b1, 1'b0, 1'b0},
      '{15, 1'b1, 1'b1, 1'b0},
      '{30, 1'b1, 1'b1, 1'b0},
      '{31, 1'b1, 1'b1, 1'b1}
    };

    rst = 1'b1;
    pll_locked = 1'b1;
    port_modprsl = '1;
    port_intl = '1;
    port_reset_req = '0;
    int_clear = '0;
    model_reset();
    steps(2);
    check_reset_values("reset");
    rst = 1'b0;
    steps(3);

    // Glitch rejection: three low cycles are one short of acceptance.
    port_modprsl[0] = 1'b0;
    steps(3);
    port_modprsl[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check("glitch_present0", port_present & P'(1), '0);
      check("glitch_resetl0",  port_resetl & P'(1), '0);
    end

    // Insertion, table-driven.
    port_modprsl[3] = 1'b0;
    n = 0;
    for (int r = 0; r < 6; r++) begin
      while (n < ins_tbl[r].edges) begin
        step();
        n++;
      end
      check($sformatf("ins_present3_e%0d", n), port_present & M3, ins_tbl[r].present ? M3 : '0);
      check($sformatf("ins_resetl3_e%0d", n),  port_resetl & M3,  ins_tbl[r].resetl ? M3 : '0);
      check($sformatf("ins_ready3_e%0d", n),   port_ready & M3,   ins_tbl[r].ready ? M3 : '0);
    end
    check("ins_others_present", port_present & ~M3, '0);
    check("ins_others_resetl",  port_resetl & ~M3,  '0);

    // PLL loss with every port ready.
    port_modprsl = '0;
    steps(40);
    check("pll_all_ready", port_ready, '1);
    pll_locked = 1'b0;
    steps(3);
    check("pll_loss_ready",  port_ready,  '0);
    check("pll_loss_resetl", port_resetl, '0);
    pll_locked = 1'b1;
    steps(3);
    check("pll_restore_resetl", port_resetl, '0);
    steps(40);
    check("pll_restore_ready", port_ready, '1);

    // Software reset of port 5, then again mid-INIT at count 10.
    port_reset_req[5] = 1'b1;
    step();
    port_reset_req[5] = 1'b0;
    check("swr_resetl5_low", port_resetl & M5, '0);
    steps(7);
    check("swr_resetl5_hold", port_resetl & M5, '0);
    step();
    check("swr_resetl5_high", port_resetl & M5, M5);
    steps(10);
    port_reset_req[5] = 1'b1;
    step();
    port_reset_req[5] = 1'b0;
    check("swr_init_resetl5_low", port_resetl & M5, '0);
    steps(7);
    check("swr_init_resetl5_hold", port_resetl & M5, '0);
    step();
    check("swr_init_resetl5_high", port_resetl & M5, M5);
    steps(15);
    check("swr_init_ready5_low", port_ready & M5, '0);
    step();
    check("swr_init_ready5_high", port_ready & M5, M5);

    // Interrupt latch on port 2.
    port_intl[2] = 1'b0;
    step();
    port_intl[2] = 1'b1;
    steps(2);
    check("int_set2", port_int, M2);
    steps(5);
    check("int_hold2", port_int, M2);
    port_intl[2] = 1'b0;
    step();
    port_intl[2] = 1'b1;
    step();
    int_clear[2] = 1'b1;
    step();
    int_clear[2] = 1'b0;
    check("int_set_wins2", port_int, M2);
    steps(3);
    int_clear[2] = 1'b1;
    step();
    int_clear[2] = 1'b0;
    check("int_clear2", port_int, '0);
    port_intl[2] = 1'b0;
    step();
    port_intl[2] = 1'b1;
    steps(2);
    check("int_reset2", port_int, M2);
    port_modprsl[2] = 1'b1;
    steps(8);
    check("int_removal2",    port_int & M2,     '0);
    check("removal_present2", port_present & M2, '0);
    check("removal_ready2",  port_ready & M2,   '0);

    // Asynchronous reset in the middle of INIT.
    port_reset_req = '1;
    step();
    port_reset_req = '0;
    steps(13);
    check("midinit_resetl", port_resetl, ~M2);
`ifdef TAXI_QSFP_LPMODE_EN
    check("midinit_lpmode", port_lpmode, '1);
`else
    check("midinit_lpmode", port_lpmode, '0);
`endif
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("async_reset");
    model_reset();
    steps(2);
    rst = 1'b0;
    steps(20);
`ifdef TAXI_QSFP_LPMODE_EN
    check("lp_init_lpmode", port_lpmode, '1);
`else
    check("lp_init_lpmode", port_lpmode, '0);
`endif
    steps(15);
    check("lp_ready", port_ready, ~M2);
`ifdef TAXI_QSFP_LPMODE_EN
    check("lp_ready_lpmode", port_lpmode, M2);
`else
    check("lp_ready_lpmode", port_lpmode, '0);
`endif

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < P; i++) begin
        if ($urandom_range(0, 99) == 0) port_modprsl[i] = ~port_modprsl[i];
        port_intl[i]      = ($urandom_range(0, 7) != 0);
        port_reset_req[i] = ($urandom_range(0, 199) == 0);
        int_clear[i]      = ($urandom_range(0, 7) == 0);
      end
      if (pll_locked && $urandom_range(0, 499) == 0)       pll_locked = 1'b0;
      else if (!pll_locked && $urandom_range(0, 19) == 0)  pll_locked = 1'b1;
      step();
    end
    port_reset_req = '0;
    int_clear = '0;
    port_intl = '1;
    steps(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
